// File: rtl/stopwatch_pkg.sv
// Shared state encoding and count limits for the stopwatch counter.
// Also holds the saturating/wrapping count step used by the top level.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [15:0] MAX_COUNT = 16'd9999;

    // Any value at or above the limit folds to zero, so the count can never leave 0..9999.
    function automatic logic [15:0] next_count(input logic [15:0] cur);
        if (cur >= MAX_COUNT) begin
            return 16'd0;
        end else begin
            return cur + 16'd1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, consecutive-cycle debouncer
// and a single-cycle press pulse on the debounced rising edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Synchronize, then accept a new level only after it has held for the full window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= {CNT_W{1'b0}};
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_counter.sv
// Tenths-of-a-second stopwatch: start/stop and clear buttons drive an
// IDLE/RUN/PAUSE machine that advances a 0..9999 count with a wrap indicator.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_DIV        = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int WRAP_HOLD       = 50_000_000
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [15:0] displayed_number,
    output logic        led1,
    output logic        led2,
    output logic        led3
);

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam int                 HOLD_W     = $clog2(WRAP_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(WRAP_HOLD);

    if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1 || WRAP_HOLD < 1 || CLK_HZ < TICK_DIV) begin : g_bad_params
        $error("stopwatch_counter: illegal parameter set");
    end

    logic w_start;
    logic w_clear;
    logic w_tick;

    state_t              r_state;
    logic [PRESC_W-1:0]  r_presc;
    logic [15:0]         r_count;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_led1;
    logic                r_led2;
    logic                r_led3;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .i_clk   (clock_100Mhz),
        .i_rst   (reset),
        .i_btn   (btn_start_stop),
        .o_press (w_start)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .i_clk   (clock_100Mhz),
        .i_rst   (reset),
        .i_btn   (btn_clear),
        .o_press (w_clear)
    );

    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST);

    // Mode machine with prescaler, count, wrap-hold timer and registered LED decodes.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_presc <= {PRESC_W{1'b0}};
            r_count <= 16'd0;
            r_hold  <= {HOLD_W{1'b0}};
            r_led1  <= 1'b0;
            r_led2  <= 1'b0;
            r_led3  <= 1'b0;
        end else begin
            if (r_hold > HOLD_W'(1)) begin
                r_hold <= r_hold - HOLD_W'(1);
            end else if (r_hold == HOLD_W'(1)) begin
                r_hold <= {HOLD_W{1'b0}};
                r_led3 <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_clear) begin
                        r_state <= ST_RUN;
                        r_presc <= {PRESC_W{1'b0}};
                        r_led1  <= 1'b1;
                        r_led2  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The cycle carrying a stop press still counts as run time.
                    if (w_tick) begin
                        r_presc <= {PRESC_W{1'b0}};
                        r_count <= next_count(r_count);
                        if (r_count >= MAX_COUNT) begin
                            r_hold <= HOLD_LOAD;
                            r_led3 <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + PRESC_W'(1);
                    end
                    if (w_start) begin
                        r_state <= ST_PAUSE;
                        r_led1  <= 1'b0;
                        r_led2  <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (w_clear) begin
                        r_state <= ST_IDLE;
                        r_presc <= {PRESC_W{1'b0}};
                        r_count <= 16'd0;
                        r_hold  <= {HOLD_W{1'b0}};
                        r_led1  <= 1'b0;
                        r_led2  <= 1'b0;
                        r_led3  <= 1'b0;
                    end else if (w_start) begin
                        r_state <= ST_RUN;
                        r_led1  <= 1'b1;
                        r_led2  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led1  <= 1'b0;
                    r_led2  <= 1'b0;
                end
            endcase
        end
    end

    assign displayed_number = r_count;
    assign led1             = r_led1;
    assign led2             = r_led2;
    assign led3             = r_led3;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (slow and fast tick) checked every
// cycle against a run-time based reference model, plus directed scenarios.
module tb_stopwatch_counter;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int TD0  = 10;
    localparam int TD1  = 2;

    logic        clock_100Mhz = 1'b0;
    logic        reset;
    logic        btn_ss [2];
    logic        btn_cl [2];
    logic [15:0] disp   [2];
    logic        l1     [2];
    logic        l2     [2];
    logic        l3     [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int TD = (g == 0) ? TD0 : TD1;

        stopwatch_counter #(
            .CLK_HZ          (100_000_000),
            .TICK_DIV        (TD),
            .DEBOUNCE_CYCLES (DEB),
            .WRAP_HOLD       (HOLD)
        ) u_dut (
            .clock_100Mhz     (clock_100Mhz),
            .reset            (reset),
            .btn_start_stop   (btn_ss[g]),
            .btn_clear        (btn_cl[g]),
            .displayed_number (disp[g]),
            .led1             (l1[g]),
            .led2             (l2[g]),
            .led3             (l3[g])
        );

        // Model: mode 0 idle, 1 run, 2 pause; rc = clock cycles spent running since the last clear.
        int     mode;
        longint rc;
        longint edge_n;
        longint wrap_edge;
        bit     wrap_v;
        bit     lvl_s, lvl_c, ev_s, ev_c;
        bit     hs[$];
        bit     hc[$];

        // A button level flips once the last DEB synchronized samples all disagree with it.
        function automatic bit flips(input bit q[$], input bit lvl);
            for (int i = 2; i < DEB + 2; i++) begin
                if (q[i] == lvl) return 1'b0;
            end
            return 1'b1;
        endfunction

        function automatic int exp_count();
            return int'((rc / TD) % 10000);
        endfunction

        function automatic int exp_led3();
            return (wrap_v && (edge_n - wrap_edge) < HOLD) ? 1 : 0;
        endfunction

        always @(posedge clock_100Mhz or posedge reset) begin
            if (reset) begin
                mode = 0; rc = 0; edge_n = 0; wrap_edge = 0; wrap_v = 1'b0;
                lvl_s = 1'b0; lvl_c = 1'b0; ev_s = 1'b0; ev_c = 1'b0;
                hs.delete(); hc.delete();
                for (int i = 0; i < DEB + 2; i++) begin
                    hs.push_back(1'b0);
                    hc.push_back(1'b0);
                end
            end else begin
                edge_n++;
                if (mode == 1) begin
                    rc++;
                    if (rc % (TD * 10000) == 0) begin
                        wrap_v = 1'b1;
                        wrap_edge = edge_n;
                    end
                end
                case (mode)
                    0: if (ev_s && !ev_c) mode = 1;
                    1: if (ev_s) mode = 2;
                    2: if (ev_c) begin mode = 0; rc = 0; wrap_v = 1'b0; end
                       else if (ev_s) mode = 1;
                    default: mode = 0;
                endcase
                hs.push_front(btn_ss[g]); void'(hs.pop_back());
                hc.push_front(btn_cl[g]); void'(hc.pop_back());
                ev_s = 1'b0;
                ev_c = 1'b0;
                if (flips(hs, lvl_s)) begin lvl_s = !lvl_s; ev_s = lvl_s; end
                if (flips(hc, lvl_c)) begin lvl_c = !lvl_c; ev_c = lvl_c; end
            end
        end

        always @(negedge clock_100Mhz) begin
            if (!reset) begin
                chk($sformatf("u%0d.disp", g), int'(disp[g]), exp_count());
                chk($sformatf("u%0d.led1", g), int'(l1[g]), (mode == 1) ? 1 : 0);
                chk($sformatf("u%0d.led2", g), int'(l2[g]), (mode == 2) ? 1 : 0);
                chk($sformatf("u%0d.led3", g), int'(l3[g]), exp_led3());
            end
        end
    end

    task automatic press(input int d, input bit s, input bit c, input int hold);
        btn_ss[d] = s;
        btn_cl[d] = c;
        repeat (hold) @(negedge clock_100Mhz);
        btn_ss[d] = 1'b0;
        btn_cl[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock_100Mhz);
    endtask

    initial begin
        int t;
        int d;
        int cnt;
        for (int i = 0; i < 2; i++) begin
            btn_ss[i] = 1'b0;
            btn_cl[i] = 1'b0;
        end
        reset = 1'b1;
        idle(3);
        for (int i = 0; i < 2; i++) begin
            chk("rst_disp", int'(disp[i]), 0);
            chk("rst_leds", int'({l1[i], l2[i], l3[i]}), 0);
        end
        reset = 1'b0;
        idle(1);

        // Start button chattering every 2 cycles never settles.
        for (int i = 0; i < 15; i++) begin
            btn_ss[0] = ~btn_ss[0];
            idle(2);
        end
        btn_ss[0] = 1'b0;
        idle(10);
        chk("bounce_disp", int'(disp[0]), 0);
        chk("bounce_led1", int'(l1[0]), 0);

        // Clean 8-cycle press on both instances; RUN begins one edge before this point.
        btn_ss[1] = 1'b1;
        press(0, 1'b1, 1'b0, 8);
        btn_ss[1] = 1'b0;
        chk("start_led1", int'(l1[0]), 1);
        idle(48);
        chk("run49_disp", int'(disp[0]), 4);
        idle(1);
        chk("run50_disp", int'(disp[0]), 5);

        // Pause so the frozen prescaler holds 6, then resume and expect the step 4 edges later.
        t = 0;
        while ((g_dut[0].rc % TD0) != 9 && t < 40) begin
            idle(1);
            t++;
        end
        chk("align_timeout", (t < 40) ? 1 : 0, 1);
        press(0, 1'b1, 1'b0, 8);
        chk("pause_led2", int'(l2[0]), 1);
        chk("pause_led1", int'(l1[0]), 0);
        d = int'(disp[0]);
        idle(100);
        chk("pause_frozen", int'(disp[0]), d);
        press(0, 1'b1, 1'b0, 8);
        chk("resume_e1", int'(disp[0]), d);
        idle(1);
        chk("resume_e2", int'(disp[0]), d);
        idle(1);
        chk("resume_e3", int'(disp[0]), d);
        idle(1);
        chk("resume_e4", int'(disp[0]), d + 1);
        idle(8);

        // Both buttons in RUN: start alone acts.
        d = int'(disp[0]);
        press(0, 1'b1, 1'b1, 8);
        chk("both_run_led2", int'(l2[0]), 1);
        chk("both_run_keep", (int'(disp[0]) >= d) ? 1 : 0, 1);
        idle(8);
        // Both buttons in PAUSE: clear wins.
        press(0, 1'b1, 1'b1, 8);
        chk("both_pause_disp", int'(disp[0]), 0);
        chk("both_pause_leds", int'({l1[0], l2[0]}), 0);
        idle(8);

        // Random presses and bounces on instance 0.
        for (int it = 0; it < 150; it++) begin
            bit use_clr;
            use_clr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                press(0, !use_clr, use_clr, $urandom_range(5, 12));
            end else begin
                int k;
                k = $urandom_range(3, 10);
                for (int j = 0; j < k; j++) begin
                    if (use_clr) btn_cl[0] = ~btn_cl[0];
                    else btn_ss[0] = ~btn_ss[0];
                    idle($urandom_range(1, 3));
                end
                btn_ss[0] = 1'b0;
                btn_cl[0] = 1'b0;
            end
            idle($urandom_range(0, 12));
        end

        // Fast instance crosses 9999 -> 0.
        t = 0;
        while (((g_dut[1].rc / TD1) % 10000) != 9998 && t < 30000) begin
            idle(1);
            t++;
        end
        chk("wrap_timeout", (t < 30000) ? 1 : 0, 1);
        chk("wrap_9998", int'(disp[1]), 9998);
        t = 0;
        while (disp[1] == 16'd9998 && t < 5) begin idle(1); t++; end
        chk("wrap_9999", int'(disp[1]), 9999);
        t = 0;
        while (disp[1] == 16'd9999 && t < 5) begin idle(1); t++; end
        chk("wrap_zero", int'(disp[1]), 0);
        chk("wrap_led3", int'(l3[1]), 1);
        cnt = 1;
        while (l3[1] && cnt < 100) begin
            idle(1);
            if (l3[1]) cnt++;
        end
        chk("led3_len", cnt, HOLD);

        // Bring instance 0 to IDLE, run to 37, then reset asynchronously.
        idle(10);
        if (g_dut[0].mode == 1) begin press(0, 1'b1, 1'b0, 8); idle(8); end
        if (g_dut[0].mode == 2) begin press(0, 1'b0, 1'b1, 8); idle(8); end
        chk("pre_rst_idle", g_dut[0].mode, 0);
        press(0, 1'b1, 1'b0, 8);
        t = 0;
        while (disp[0] != 16'd37 && t < 600) begin idle(1); t++; end
        chk("reach_37", int'(disp[0]), 37);
        @(posedge clock_100Mhz);
        #3 reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_rst_disp", int'(disp[i]), 0);
            chk("async_rst_leds", int'({l1[i], l2[i], l3[i]}), 0);
        end
        btn_ss[0] = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(6);
        chk("post_rst_idle", int'(l1[0]), 0);
        idle(1);
        chk("post_rst_press", int'(l1[0]), 1);
        btn_ss[0] = 1'b0;
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_DIV, default 10_000_000, clock cycles per count step (0.1 s at 100 MHz); legal range 2 or more.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles a button needs before it is accepted (10 ms); legal range 1 or more.
REQ-004 Parameter WRAP_HOLD, default 50_000_000, cycles led3 stays high after a wrap.
REQ-005 clock_100Mhz  input  1  system clock, all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high.
REQ-007 btn_start_stop  input  1  raw asynchronous push-button, high = pressed.
REQ-008 btn_clear  input  1  raw asynchronous push-button, high = pressed.
REQ-009 displayed_number  output  16  binary count 0..9999, consumed by the seven-segment display controller.
REQ-010 led1  output  1  high while in RUN.
REQ-011 led2  output  1  high while in PAUSE.
REQ-012 led3  output  1  wrap indicator.

Function
REQ-013 Each button passes through a 2-flop synchronizer, then a debouncer: debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A press event is a 1-cycle pulse on the debounced level's 0->1 edge; releases generate no event.
REQ-015 FSM states IDLE, RUN, PAUSE; reset state IDLE.
REQ-016 IDLE: start event -> RUN with prescaler cleared to 0; clear event -> stay IDLE.
REQ-017 RUN: start event -> PAUSE; clear event ignored.
REQ-018 PAUSE: start event -> RUN with prescaler value preserved, no fraction lost; clear event -> IDLE with count set to 0 and prescaler set to 0.
REQ-019 Simultaneous start and clear events: in PAUSE clear wins (-> IDLE); in IDLE clear wins (no state change); in RUN start acts alone.
REQ-020 Prescaler counts 0..TICK_DIV-1 only in RUN and is frozen in PAUSE; tick = 1-cycle pulse when it equals TICK_DIV-1, after which it returns to 0.
REQ-021 On tick, count increments by 1; 9999 wraps to 0 on the same edge and raises a wrap pulse.
REQ-022 displayed_number is registered and changes on the clock edge that consumes the tick (latency 1 cycle from tick).
REQ-023 led3 goes high on the wrap edge for exactly WRAP_HOLD cycles; a new wrap during the hold reloads the full hold; clear -> IDLE forces led3 low.
REQ-024 led1 and led2 are registered decodes of the state, never high together; both are low in IDLE.
REQ-025 The count never exceeds 9999 under any sequence of inputs.

Reset
REQ-026 Assertion, asynchronous: state=IDLE, count=0, prescaler=0, debounced levels=0, synchronizers=0, hold counter=0, displayed_number=0, led1=led2=led3=0.
REQ-027 Reset mid-RUN or mid-debounce discards all progress; after deassertion a button held continuously produces one press event after the full debounce time.

Structure
REQ-028 Shared package stopwatch_pkg holds the FSM state enum and constant MAX_COUNT=9999.
REQ-029 Sub-module btn_debounce (synchronizer + debouncer + edge pulse, parameter DEBOUNCE_CYCLES) is instantiated once per button.
REQ-030 Counter widths are derived via $clog2 of TICK_DIV, DEBOUNCE_CYCLES and WRAP_HOLD.

Verification (bench parameters TICK_DIV=10, DEBOUNCE_CYCLES=4, WRAP_HOLD=20)
REQ-031 Start press held 8 cycles -> one event, led1=1; after 50 cycles displayed_number=5.
REQ-032 btn_start_stop toggling every 2 cycles for 30 cycles -> no event; state stays IDLE and displayed_number stays 0.
REQ-033 Pause at a prescaler value of 6, wait 100 cycles, then resume -> next increment 4 cycles after resume takes effect; led2=1 during the pause.
REQ-034 Count preloaded by running to 9998, two ticks -> 9999 then 0; led3=1 for exactly 20 cycles.
REQ-035 Start and clear pressed in the same cycle while in PAUSE -> IDLE, displayed_number=0, led1=led2=0; the same pair pressed in RUN -> PAUSE with the count kept.
REQ-036 Reset asserted mid-RUN at count 37, asynchronous to the clock -> all outputs 0 immediately; state IDLE after release.
